// File: rtl/alu_core.sv
// alu_core: handshaked ALU, single-cycle logic/arithmetic ops plus an optional
// shift-add multiplier that is built only when ALU_MUL_EN is defined.
module alu_core #(
    parameter int WIDTH = 6,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       out_flags,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam int         CW     = $clog2(WIDTH + 1);
`endif

    localparam logic [SHW:0] SH_MAX = (SHW + 1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t state;
    logic   accept;

    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
    logic             c;
    logic             v;
    logic             e;
    logic [SHW:0]     sh;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_acc;
    logic [CW-1:0]      mul_cnt;
`endif

    // In HOLD a new request can only enter on the same edge the result leaves.
    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        e   = 1'b0;
        sh  = ({1'b0, b_in[SHW-1:0]} > SH_MAX) ? SH_MAX : {1'b0, b_in[SHW-1:0]};
        case (op_in)
            OP_ADD: begin
                {c, res} = {1'b0, a_in} + {1'b0, b_in};
                v = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                {c, res} = {1'b0, a_in} - {1'b0, b_in};
                v = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_AND: res = a_in & b_in;
            OP_OR:  res = a_in | b_in;
            OP_XOR: res = a_in ^ b_in;
            // The extra bit beside the operand catches the last bit shifted out.
            OP_SHL: {c, res} = {1'b0, a_in} << sh;
            OP_SHR: {res, c} = {a_in, 1'b0} >> sh;
            OP_NOP: ;
`ifdef ALU_MUL_EN
            OP_MUL: ;
`endif
            default: e = 1'b1;
        endcase
        flags = {e, v, c, (res == '0)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out       <= '0;
            out_flags <= '0;
            out_valid <= 1'b0;
`ifdef ALU_MUL_EN
            mul_a     <= '0;
            mul_b     <= '0;
            mul_acc   <= '0;
            mul_cnt   <= '0;
`endif
        end else if (accept) begin
            case (op_in)
                OP_NOP: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
`ifdef ALU_MUL_EN
                OP_MUL: begin
                    mul_a     <= {{WIDTH{1'b0}}, a_in};
                    mul_b     <= b_in;
                    mul_acc   <= '0;
                    mul_cnt   <= '0;
                    out_valid <= 1'b0;
                    state     <= BUSY;
                end
`endif
                default: begin
                    out       <= res;
                    out_flags <= flags;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
            endcase
        end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end
`ifdef ALU_MUL_EN
        // WIDTH shift-add steps, then one extra cycle to publish the product.
        else if (state == BUSY) begin
            if (mul_cnt == CW'(WIDTH)) begin
                out       <= mul_acc[WIDTH-1:0];
                out_flags <= {2'b00, |mul_acc[2*WIDTH-1:WIDTH], (mul_acc[WIDTH-1:0] == '0)};
                out_valid <= 1'b1;
                state     <= HOLD;
            end else begin
                mul_acc <= mul_acc + (mul_b[0] ? mul_a : '0);
                mul_a   <= mul_a << 1;
                mul_b   <= mul_b >> 1;
                mul_cnt <= mul_cnt + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core at WIDTH = 6; MUL cases follow ALU_MUL_EN.
module tb_alu_core;

    localparam int W = 6;

    localparam logic [3:0] NOP = 4'd0;
    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] AND = 4'd3;
    localparam logic [3:0] OR  = 4'd4;
    localparam logic [3:0] XOR = 4'd5;
    localparam logic [3:0] SHL = 4'd6;
    localparam logic [3:0] SHR = 4'd7;
    localparam logic [3:0] MUL = 4'd8;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   op_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic [3:0]   out_flags;
    logic         out_valid;
    logic         out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_in     (op_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_flags (out_flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_in    = op;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        tests++; if (out !== 6'd0) begin fails++; $display("[TB] FAIL reset_out: got %0d expected 0", out); end
        tests++; if (out_flags !== 4'b0000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 0000", out_flags); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
        rst = 1'b1;
    endtask

    task automatic test_single_cycle();
        vec_t v [17];
        v = '{
            '{ADD,   6'd60, 6'd5,  6'd1,  4'b0010},
            '{ADD,   6'd31, 6'd1,  6'd32, 4'b0100},
            '{ADD,   6'd32, 6'd32, 6'd0,  4'b0111},
            '{SUB,   6'd3,  6'd5,  6'd62, 4'b0010},
            '{SUB,   6'd9,  6'd9,  6'd0,  4'b0001},
            '{SUB,   6'd32, 6'd1,  6'd31, 4'b0100},
            '{AND,   6'd60, 6'd15, 6'd12, 4'b0000},
            '{OR,    6'd40, 6'd3,  6'd43, 4'b0000},
            '{XOR,   6'd42, 6'd42, 6'd0,  4'b0001},
            '{SHL,   6'd33, 6'd1,  6'd2,  4'b0010},
            '{SHL,   6'd1,  6'd6,  6'd0,  4'b0011},
            '{SHL,   6'd3,  6'd8,  6'd3,  4'b0000},
            '{SHR,   6'd6,  6'd0,  6'd6,  4'b0000},
            '{SHR,   6'd33, 6'd7,  6'd0,  4'b0011},
            '{SHR,   6'd44, 6'd2,  6'd11, 4'b0000},
            '{4'd12, 6'd7,  6'd3,  6'd0,  4'b1001},
            '{4'd15, 6'd5,  6'd5,  6'd0,  4'b1001}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(v[i].op, v[i].a, v[i].b);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL vec%0d_valid: got %b expected 1", i, out_valid); end
            tests++; if (out !== v[i].r) begin fails++; $display("[TB] FAIL vec%0d_out: got %0d expected %0d", i, out, v[i].r); end
            tests++; if (out_flags !== v[i].f) begin fails++; $display("[TB] FAIL vec%0d_flags: got %b expected %b", i, out_flags, v[i].f); end
        end
        @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL drain_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_nop();
        out_ready = 1'b1;
        send(NOP, 6'd3, 6'd4);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL nop_valid: got %b expected 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL nop_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_mul();
`ifdef ALU_MUL_EN
        logic [W-1:0] exp_r [2];
        logic [3:0]   exp_f [2];
        logic [W-1:0] ma    [2];
        logic [W-1:0] mb    [2];
        ma[0] = 6'd7; mb[0] = 6'd9; exp_r[0] = 6'd63; exp_f[0] = 4'b0000;
        ma[1] = 6'd9; mb[1] = 6'd9; exp_r[1] = 6'd17; exp_f[1] = 4'b0010;
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            send(MUL, ma[m], mb[m]);
            a_in = 6'd63;
            b_in = 6'd63;
            for (int k = 1; k <= W + 1; k++) begin
                @(posedge clk);
                #1;
                if (k <= W) begin
                    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL mul%0d_busy_ready_c%0d: got %b expected 0", m, k, in_ready); end
                    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mul%0d_early_valid_c%0d: got %b expected 0", m, k, out_valid); end
                end else begin
                    tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mul%0d_valid: got %b expected 1", m, out_valid); end
                    tests++; if (out !== exp_r[m]) begin fails++; $display("[TB] FAIL mul%0d_out: got %0d expected %0d", m, out, exp_r[m]); end
                    tests++; if (out_flags !== exp_f[m]) begin fails++; $display("[TB] FAIL mul%0d_flags: got %b expected %b", m, out_flags, exp_f[m]); end
                end
            end
            @(posedge clk);
            #1;
        end
`else
        out_ready = 1'b1;
        send(MUL, 6'd7, 6'd9);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mul_illegal_valid: got %b expected 1", out_valid); end
        tests++; if (out !== 6'd0) begin fails++; $display("[TB] FAIL mul_illegal_out: got %0d expected 0", out); end
        tests++; if (out_flags !== 4'b1001) begin fails++; $display("[TB] FAIL mul_illegal_flags: got %b expected 1001", out_flags); end
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(ADD, 6'd1, 6'd2);
        tests++; if (out !== 6'd3) begin fails++; $display("[TB] FAIL bp_first_out: got %0d expected 3", out); end
        op_in    = ADD;
        a_in     = 6'd4;
        b_in     = 6'd4;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            tests++; if (out !== 6'd3) begin fails++; $display("[TB] FAIL bp_out_c%0d: got %0d expected 3", k, out); end
            tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid_c%0d: got %b expected 1", k, out_valid); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_ready_c%0d: got %b expected 0", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++; if (out !== 6'd8) begin fails++; $display("[TB] FAIL b2b_out: got %0d expected 8", out); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_valid: got %b expected 1", out_valid); end
        tests++; if (out_flags !== 4'b0000) begin fails++; $display("[TB] FAIL b2b_flags: got %b expected 0000", out_flags); end
        @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_drain_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midop();
`ifdef ALU_MUL_EN
        out_ready = 1'b1;
        send(MUL, 6'd5, 6'd5);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
`else
        out_ready = 1'b0;
        send(ADD, 6'd60, 6'd5);
`endif
        rst = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid); end
        tests++; if (out !== 6'd0) begin fails++; $display("[TB] FAIL midrst_out: got %0d expected 0", out); end
        tests++; if (out_flags !== 4'b0000) begin fails++; $display("[TB] FAIL midrst_flags: got %b expected 0000", out_flags); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL postrst_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk);
            #1;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL postrst_stale_c%0d: got %b expected 0", k, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        op_in     = NOP;
        a_in      = '0;
        b_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single_cycle();
        test_nop();
        test_mul();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
